// File: rtl/ocd_sram_arb_pkg.sv
// Shared types and constants for the OCD SRAM bank arbiter: FSM encoding,
// legal read-latency range and the built-in read-check pattern.
package ocd_sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } arb_state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  // Expected content of a pre-loaded bank: low address byte, inverted for bank B.
  function automatic logic [7:0] chk_pattern(input logic [7:0] addr_lo, input logic bank);
    return addr_lo ^ {8{bank}};
  endfunction

endpackage

// File: rtl/ocd_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer only moves when a grant is issued.
module ocd_rr_arbiter2
  import ocd_sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       en_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  // ptr_q names the requester favoured on a tie; reset favours r0.
  logic ptr_q;

  assign gnt_vld_o = en_i & (|req_i);
  assign gnt_idx_o = (&req_i) ? ptr_q : req_i[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ptr_q <= 1'b0;
    else if (gnt_vld_o) ptr_q <= ~gnt_idx_o;
  end

endmodule

// File: rtl/ocd_sram_bank_arbiter.sv
// Two-requester arbiter for the A/B SRAM macro pair and its output mux.
// Optional read checker enabled by defining OCD_SRAM_ARB_CHECK_EN.
module ocd_sram_bank_arbiter
  import ocd_sram_arb_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int RD_LAT = 1
) (
`ifdef USE_POWER_PINS
  inout  wire               vdd,
  inout  wire               vss,
`endif
`ifdef OCD_SRAM_ARB_CHECK_EN
  input  logic              err_clr,
  output logic [7:0]        err_cnt,
`endif
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_bank,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [7:0]        r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_bank,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [7:0]        r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [7:0]        rdata,
  output logic              busy,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_d,
  output logic              sram_gwen_n,
  output logic              sram_cen_a_n,
  output logic              sram_cen_b_n,
  output logic              mux_s,
  input  logic [7:0]        mux_y
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_rd_lat
    $error("ocd_sram_bank_arbiter: RD_LAT must be within 1..3");
  end

  localparam logic [1:0] WAIT_LAST = (RD_LAT > 1) ? 2'(RD_LAT - 2) : 2'd0;

  arb_state_e        state_q, state_d;
  logic [1:0]        wait_q, wait_d;
  logic              we_q, bank_q, who_q, mux_s_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q, rdata_q;
  logic [1:0]        rvalid_q;
  logic              grant, gidx, acc, cap;
  logic              sel_we, sel_bank;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_wdata;

  ocd_rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     ({r1_req, r0_req}),
    .en_i      (state_q == ST_IDLE),
    .gnt_vld_o (grant),
    .gnt_idx_o (gidx)
  );

  assign sel_we    = gidx ? r1_we    : r0_we;
  assign sel_bank  = gidx ? r1_bank  : r0_bank;
  assign sel_addr  = gidx ? r1_addr  : r0_addr;
  assign sel_wdata = gidx ? r1_wdata : r0_wdata;

  assign acc = (state_q == ST_ACCESS);
  assign cap = (state_q == ST_CAPTURE);

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      ST_IDLE:    if (grant) state_d = ST_ACCESS;
      ST_ACCESS: begin
        wait_d = 2'd0;
        if (we_q)             state_d = ST_IDLE;
        else if (RD_LAT == 1) state_d = ST_CAPTURE;
        else                  state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_q == WAIT_LAST) state_d = ST_CAPTURE;
        else                     wait_d  = wait_q + 2'd1;
      end
      ST_CAPTURE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Request fields are frozen at the grant edge; mux_s only moves for reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q     <= 1'b0;
      bank_q   <= 1'b0;
      who_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 8'h00;
      mux_s_q  <= 1'b0;
      rdata_q  <= 8'h00;
      rvalid_q <= 2'b00;
    end else begin
      if (grant) begin
        we_q    <= sel_we;
        bank_q  <= sel_bank;
        who_q   <= gidx;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
        if (!sel_we) mux_s_q <= sel_bank;
      end
      if (cap) rdata_q <= mux_y;
      rvalid_q <= {cap & who_q, cap & ~who_q};
    end
  end

  // SRAM pins are decoded from state so an async reset releases them at once.
  assign sram_cen_a_n = ~(acc & ~bank_q);
  assign sram_cen_b_n = ~(acc &  bank_q);
  assign sram_gwen_n  = ~(acc &  we_q);
  assign sram_addr    = acc ? addr_q  : '0;
  assign sram_d       = acc ? wdata_q : 8'h00;
  assign r0_gnt       = acc & ~who_q;
  assign r1_gnt       = acc &  who_q;
  assign r0_rvalid    = rvalid_q[0];
  assign r1_rvalid    = rvalid_q[1];
  assign rdata        = rdata_q;
  assign busy         = (state_q != ST_IDLE);
  assign mux_s        = mux_s_q;

`ifdef OCD_SRAM_ARB_CHECK_EN
  logic [7:0] err_cnt_q;
  logic       miss;

  assign miss = cap && (mux_y != chk_pattern(addr_q[7:0], bank_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          err_cnt_q <= 8'h00;
    else if (err_clr)                    err_cnt_q <= 8'h00;
    else if (miss && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_ocd_sram_bank_arbiter.sv
// Bench for ocd_sram_bank_arbiter: directed cases plus random traffic
// against a cycle-timeline reference model.
module tb_ocd_sram_bank_arbiter;

  localparam int ADDR_W = 9;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req   [2];
  logic              we    [2];
  logic              bank  [2];
  logic [ADDR_W-1:0] addr  [2];
  logic [7:0]        wdata [2];
  logic              r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, busy;
  logic [7:0]        rdata, sram_d, mux_y;
  logic [ADDR_W-1:0] sram_addr;
  logic              sram_gwen_n, sram_cen_a_n, sram_cen_b_n, mux_s;
`ifdef OCD_SRAM_ARB_CHECK_EN
  logic              err_clr;
  logic [7:0]        err_cnt;
`endif

  always #5 clk = ~clk;

  ocd_sram_bank_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(LAT)) dut (
`ifdef OCD_SRAM_ARB_CHECK_EN
    .err_clr      (err_clr),
    .err_cnt      (err_cnt),
`endif
    .clk          (clk),
    .rst_n        (rst_n),
    .r0_req       (req[0]),
    .r0_we        (we[0]),
    .r0_bank      (bank[0]),
    .r0_addr      (addr[0]),
    .r0_wdata     (wdata[0]),
    .r0_gnt       (r0_gnt),
    .r0_rvalid    (r0_rvalid),
    .r1_req       (req[1]),
    .r1_we        (we[1]),
    .r1_bank      (bank[1]),
    .r1_addr      (addr[1]),
    .r1_wdata     (wdata[1]),
    .r1_gnt       (r1_gnt),
    .r1_rvalid    (r1_rvalid),
    .rdata        (rdata),
    .busy         (busy),
    .sram_addr    (sram_addr),
    .sram_d       (sram_d),
    .sram_gwen_n  (sram_gwen_n),
    .sram_cen_a_n (sram_cen_a_n),
    .sram_cen_b_n (sram_cen_b_n),
    .mux_s        (mux_s),
    .mux_y        (mux_y)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a timeline of the current transaction.
  // gc = cycle the grant is visible (ACCESS), nidle = first idle cycle after it,
  // rvc = cycle rvalid is due, last = requester granted most recently.
  int k, gc, nidle, rvc, who, last;
  int gwe, gbank, gaddr, gwd, rdm, muxm, errm;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic mreset();
    gc = -100; nidle = 0; rvc = -100; who = 0; last = 1;
    gwe = 0; gbank = 0; gaddr = 0; gwd = 0; rdm = 0; muxm = 0; errm = 0;
  endtask

  task automatic check_now();
    bit acc;
    acc = (k == gc);
    chk("r0_gnt",    32'(r0_gnt),       32'(acc && who == 0));
    chk("r1_gnt",    32'(r1_gnt),       32'(acc && who == 1));
    chk("r0_rvalid", 32'(r0_rvalid),    32'(k == rvc && who == 0));
    chk("r1_rvalid", 32'(r1_rvalid),    32'(k == rvc && who == 1));
    chk("rdata",     32'(rdata),        32'(rdm));
    chk("busy",      32'(busy),         32'(k >= gc && k < nidle));
    chk("sram_addr", 32'(sram_addr),    acc ? 32'(gaddr) : 32'd0);
    chk("sram_d",    32'(sram_d),       acc ? 32'(gwd)   : 32'd0);
    chk("gwen_n",    32'(sram_gwen_n),  32'(!(acc && gwe == 1)));
    chk("cen_a_n",   32'(sram_cen_a_n), 32'(!(acc && gbank == 0)));
    chk("cen_b_n",   32'(sram_cen_b_n), 32'(!(acc && gbank == 1)));
    chk("mux_s",     32'(mux_s),        32'(muxm));
`ifdef OCD_SRAM_ARB_CHECK_EN
    chk("err_cnt",   32'(err_cnt),      32'(errm));
`endif
  endtask

  // Advance one cycle: apply the edge just passed to the model, then compare.
  task automatic cyc();
    bit cap;
    int w;
    @(negedge clk);
    k++;
    cap = (gwe == 0) && (k - 1 == gc + LAT);
    if (cap) begin
      rdm = int'(mux_y);
      rvc = k;
    end
`ifdef OCD_SRAM_ARB_CHECK_EN
    if (err_clr) errm = 0;
    else if (cap && mux_y != (8'(gaddr) ^ {8{gbank[0]}}) && errm < 255) errm++;
`endif
    if (k - 1 >= nidle && (req[0] || req[1])) begin
      w     = (req[0] && req[1]) ? 1 - last : (req[1] ? 1 : 0);
      last  = w;
      who   = w;
      gc    = k;
      gwe   = int'(we[w]);
      gbank = int'(bank[w]);
      gaddr = int'(addr[w]);
      gwd   = int'(wdata[w]);
      nidle = gwe ? k + 1 : k + LAT + 1;
      if (!gwe) muxm = gbank;
    end
    check_now();
  endtask

  function automatic bit granted(input int n);
    return (k == gc) && (who == n);
  endfunction

  task automatic issue(input int n, input bit w, input bit b, input logic [ADDR_W-1:0] a,
                       input logic [7:0] d, input logic [7:0] y);
    int t;
    we[n] = w; bank[n] = b; addr[n] = a; wdata[n] = d; mux_y = y; req[n] = 1'b1;
    t = 0;
    do begin cyc(); t++; end while (!granted(n) && t < 40);
    if (!granted(n)) chk("grant_timeout", 32'd0, 32'd1);
    req[n] = 1'b0;
    t = 0;
    while (k <= nidle && t < 40) begin cyc(); t++; end
  endtask

  task automatic rand_fields(input int n);
    we[n]    = 1'($urandom_range(0, 1));
    bank[n]  = 1'($urandom_range(0, 1));
    addr[n]  = ADDR_W'($urandom);
    wdata[n] = 8'($urandom);
  endtask

  initial begin
    int order[$];
    int t;
    rst_n = 1'b0;
    mux_y = 8'h00;
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0; we[n] = 1'b0; bank[n] = 1'b0; addr[n] = '0; wdata[n] = 8'h00;
    end
`ifdef OCD_SRAM_ARB_CHECK_EN
    err_clr = 1'b0;
`endif
    k = 0;
    mreset();
    repeat (2) @(negedge clk);
    check_now();
    rst_n = 1'b1;

    issue(0, 1'b1, 1'b0, 9'h005, 8'h3C, 8'h00);
    issue(1, 1'b0, 1'b1, 9'h005, 8'h00, 8'hA5);
    chk("rdata_a5", 32'(rdata), 32'h0A5);
    chk("mux_s_held", 32'(mux_s), 32'd1);

    // Read on r0, then async reset while the read is in WAIT.
    we[0] = 1'b0; bank[0] = 1'b0; addr[0] = 9'h0AA; mux_y = 8'h5A; req[0] = 1'b1;
    t = 0;
    do begin cyc(); t++; end while (!granted(0) && t < 40);
    req[0] = 1'b0;
    cyc();
    chk("in_wait_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 mreset();
    check_now();
    for (int n = 0; n < 2; n++) begin
      we[n] = 1'b1; bank[n] = 1'(n); addr[n] = ADDR_W'(n + 16); wdata[n] = 8'(n + 8'h40); req[n] = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (k == gc) order.push_back(who);
    end
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(i % 2));
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (LAT + 2) cyc();

    for (int i = 0; i < 2500; i++) begin
      for (int n = 0; n < 2; n++) begin
        if (req[n] && granted(n)) begin
          req[n] = 1'($urandom_range(0, 1));
          rand_fields(n);
        end else if (!req[n]) begin
          if ($urandom_range(0, 3) == 0) begin req[n] = 1'b1; rand_fields(n); end
        end else if ($urandom_range(0, 31) == 0) begin
          req[n] = 1'b0;
        end
      end
      mux_y = 8'($urandom);
`ifdef OCD_SRAM_ARB_CHECK_EN
      err_clr = ($urandom_range(0, 15) == 0);
`endif
      cyc();
    end
    req[0] = 1'b0; req[1] = 1'b0;
    repeat (LAT + 2) cyc();

`ifdef OCD_SRAM_ARB_CHECK_EN
    err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
    issue(1, 1'b0, 1'b1, 9'h012, 8'h00, 8'hED);
    chk("err_pass", 32'(err_cnt), 32'd0);
    issue(1, 1'b0, 1'b1, 9'h012, 8'h00, 8'h00);
    chk("err_one", 32'(err_cnt), 32'd1);
    for (int i = 0; i < 300; i++) issue(i % 2, 1'b0, 1'b1, 9'h012, 8'h00, 8'h00);
    chk("err_sat", 32'(err_cnt), 32'd255);
    err_clr = 1'b1; cyc(); err_clr = 1'b0; cyc();
    chk("err_clr", 32'(err_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
